// File: rtl/alu_seq.sv
// Handshaked successor ALU for the fauxCPU datapath: single-cycle arithmetic/logic ops,
// a multi-cycle restoring divider, and registered result/remainder/flag outputs.
module alu_seq #(
  parameter int WIDTH = 36,
  parameter int OP_W  = 5,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic [3:0]       flags,
  output logic             Cout
);

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(3);
  localparam logic [OP_W-1:0] OP_EQUAL  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_DIVIDE = OP_W'(5);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               accept_s, div_go_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [WIDTH-1:0]   res_out_s, res_rem_s;
  logic               res_c_s, res_v_s;
  logic [WIDTH-1:0]   quo_r, dvs_r, prem_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH-1:0]   step_s, prem_next_s, quo_next_s;
  logic               borrow_s, qbit_s;
  logic [WIDTH-1:0]   out_r, rem_r;
  logic [3:0]         flags_r;
  logic               out_valid_r;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] value,
                                            input logic carry, input logic ovf);
    return {(value == {WIDTH{1'b0}}), value[WIDTH-1], carry, ovf};
  endfunction

  assign accept_s  = in_valid && (state_r == S_IDLE);
  assign div_go_s  = (op == OP_DIVIDE) && (in2 != {WIDTH{1'b0}});
  assign in_ready  = (state_r == S_IDLE);
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign rem       = rem_r;
  assign flags     = flags_r;
  assign Cout      = flags_r[1];

  // Single-cycle result from the operands presented at accept time
  always_comb begin
    sum_s     = {1'b0, in1} + {1'b0, in2};
    diff_s    = {1'b0, in1} - {1'b0, in2};
    res_out_s = {WIDTH{1'b0}};
    res_rem_s = {WIDTH{1'b0}};
    res_c_s   = 1'b0;
    res_v_s   = 1'b0;
    case (op)
      OP_ADD: begin
        res_out_s = sum_s[WIDTH-1:0];
        res_c_s   = sum_s[WIDTH];
        res_v_s   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_s[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_out_s = diff_s[WIDTH-1:0];
        res_c_s   = diff_s[WIDTH];
        res_v_s   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_s[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:   res_out_s = in1 & in2;
      OP_OR:    res_out_s = in1 | in2;
      OP_EQUAL: res_out_s = (in1 == in2) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
      // Only reached as a result for a zero divisor; nonzero divisors iterate
      OP_DIVIDE: begin
        res_out_s = {WIDTH{1'b1}};
        res_rem_s = in1;
        res_v_s   = 1'b1;
      end
      default: res_out_s = {WIDTH{1'b0}};
    endcase
  end

  // One restoring-division step on a WIDTH+1 bit shifted partial remainder
  always_comb begin
    shift_s             = {prem_r, quo_r[WIDTH-1]};
    {borrow_s, step_s}  = {1'b0, shift_s[WIDTH-1:0]} - {1'b0, dvs_r};
    qbit_s              = shift_s[WIDTH] | ~borrow_s;
    prem_next_s         = qbit_s ? step_s : shift_s[WIDTH-1:0];
    quo_next_s          = {quo_r[WIDTH-2:0], qbit_s};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = div_go_s ? S_DIV : S_DONE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DIV: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = S_DONE;
        end else begin
          state_s = S_DIV;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Divider datapath and registered result; results only land on completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_r       <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      prem_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      out_r       <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_s == S_DONE);
      case (state_r)
        S_IDLE: begin
          if (accept_s && div_go_s) begin
            quo_r  <= in1;
            dvs_r  <= in2;
            prem_r <= {WIDTH{1'b0}};
            cnt_r  <= CNT_W'(WIDTH - 1);
          end else if (accept_s) begin
            out_r   <= res_out_s;
            rem_r   <= res_rem_s;
            flags_r <= make_flags(res_out_s, res_c_s, res_v_s);
          end
        end
        S_DIV: begin
          quo_r  <= quo_next_s;
          prem_r <= prem_next_s;
          cnt_r  <= cnt_r - CNT_W'(1);
          if (cnt_r == {CNT_W{1'b0}}) begin
            out_r   <= quo_next_s;
            rem_r   <= prem_next_s;
            flags_r <= make_flags(quo_next_s, 1'b0, 1'b0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=36 and WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                         OP_EQUAL = 5'd4, OP_DIVIDE = 5'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, cout;
  logic [4:0]  op = 5'd0;
  logic [35:0] in1 = 36'd0, in2 = 36'd0, out, rem;
  logic [3:0]  flags;
  logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid, b_cout;
  logic [4:0]  b_op = 5'd0;
  logic [7:0]  b_in1 = 8'd0, b_in2 = 8'd0, b_out, b_rem;
  logic [3:0]  b_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(36), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .rem(rem), .flags(flags), .Cout(cout)
  );

  alu_seq #(.WIDTH(8), .OP_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .op(b_op),
    .in1(b_in1), .in2(b_in2), .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out),
    .rem(b_rem), .flags(b_flags), .Cout(b_cout)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain integer arithmetic on w-bit unsigned/signed values
  function automatic void model(input int w, input logic [4:0] mop, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] eo,
                                output logic [63:0] er, output logic [3:0] ef, output int elat);
    logic [63:0] mask, top;
    longint sa, sb, sres, smax, smin;
    logic c, v;
    mask = (64'd1 << w) - 64'd1;
    top  = 64'd1 << (w - 1);
    sa   = ((a & top) != 64'd0) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = ((b & top) != 64'd0) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    smax = longint'(top) - 1;
    smin = -longint'(top);
    c = 1'b0; v = 1'b0; er = 64'd0; elat = 1; eo = 64'd0;
    case (mop)
      OP_ADD: begin
        eo = (a + b) & mask; c = (a + b) > mask;
        sres = sa + sb; v = (sres > smax) || (sres < smin);
      end
      OP_SUB: begin
        eo = (a - b) & mask; c = a < b;
        sres = sa - sb; v = (sres > smax) || (sres < smin);
      end
      OP_AND:   eo = a & b;
      OP_OR:    eo = a | b;
      OP_EQUAL: eo = (a == b) ? 64'd1 : 64'd0;
      OP_DIVIDE: begin
        if (b == 64'd0) begin eo = mask; er = a; v = 1'b1; end
        else begin eo = a / b; er = a % b; elat = w + 1; end
      end
      default: eo = 64'd0;
    endcase
    ef = {eo == 64'd0, (eo & top) != 64'd0, c, v};
  endfunction

  function automatic logic [63:0] rand_opnd(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return 64'({$urandom_range(0, 20)});
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  // Drives one transaction, scrambles operands after accept, returns result and latency (-1 on timeout)
  task automatic run_op(input bit narrow, input logic [4:0] o_op, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] ro, output logic [63:0] rr,
                        output logic [3:0] rf, output logic rc, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!(narrow ? b_in_ready : in_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (narrow) begin b_op = o_op; b_in1 = a[7:0]; b_in2 = b[7:0]; b_in_valid = 1'b1; end
    else begin op = o_op; in1 = a[35:0]; in2 = b[35:0]; in_valid = 1'b1; end
    @(posedge clk); #1;
    in_valid = 1'b0; b_in_valid = 1'b0;
    in1 = {$urandom, $urandom}; in2 = {$urandom, $urandom}; op = 5'($urandom);
    b_in1 = 8'($urandom); b_in2 = 8'($urandom); b_op = 5'($urandom);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (narrow ? b_out_valid : out_valid) begin lat = k; break; end
    end
    ro = narrow ? {56'd0, b_out} : {28'd0, out};
    rr = narrow ? {56'd0, b_rem} : {28'd0, rem};
    rf = narrow ? b_flags : flags;
    rc = narrow ? b_cout : cout;
    if (lat > 0) begin
      if (narrow) b_out_ready = 1'b1; else out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; b_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, out, rem, flags, cout} !== {1'b0, 1'b1, 36'd0, 36'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset36: valid=%b ready=%b out=%h rem=%h flags=%b cout=%b, required 0 1 0 0 0 0",
               out_valid, in_ready, out, rem, flags, cout);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_out, b_rem, b_flags, b_cout} !== {1'b0, 1'b1, 8'd0, 8'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset8: valid=%b ready=%b out=%h rem=%h flags=%b, required 0 1 0 0 0",
               b_out_valid, b_in_ready, b_out, b_rem, b_flags);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_valid: out_valid=%b/%b, required 0/0", out_valid, b_out_valid);
    end
  endtask

  typedef struct {
    bit          narrow;
    logic [4:0]  vop;
    logic [63:0] a, b, eo, er;
    logic [3:0]  ef;
    logic        ec;
    int          elat;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[10];
    logic [63:0] ro, rr;
    logic [3:0] rf;
    logic rc;
    int lat;
    tbl[0] = '{1'b0, OP_ADD,    64'hF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 4'b1010, 1'b1, 1};
    tbl[1] = '{1'b0, OP_SUB,    64'd5, 64'd7, 64'hF_FFFF_FFFE, 64'd0, 4'b0110, 1'b1, 1};
    tbl[2] = '{1'b0, OP_DIVIDE, 64'd100, 64'd7, 64'd14, 64'd2, 4'b0000, 1'b0, 37};
    tbl[3] = '{1'b0, OP_DIVIDE, 64'd9, 64'd0, 64'hF_FFFF_FFFF, 64'd9, 4'b0101, 1'b0, 1};
    tbl[4] = '{1'b0, 5'd31,     64'd12, 64'd34, 64'd0, 64'd0, 4'b1000, 1'b0, 1};
    tbl[5] = '{1'b0, OP_EQUAL,  64'd77, 64'd77, 64'd1, 64'd0, 4'b0000, 1'b0, 1};
    tbl[6] = '{1'b0, OP_EQUAL,  64'd77, 64'd78, 64'd0, 64'd0, 4'b1000, 1'b0, 1};
    tbl[7] = '{1'b0, OP_ADD,    64'h7_FFFF_FFFF, 64'd1, 64'h8_0000_0000, 64'd0, 4'b0101, 1'b0, 1};
    tbl[8] = '{1'b0, OP_OR,     64'hF00, 64'h00F, 64'hF0F, 64'd0, 4'b0000, 1'b0, 1};
    tbl[9] = '{1'b1, OP_DIVIDE, 64'd255, 64'd16, 64'd15, 64'd15, 4'b0000, 1'b0, 9};
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].narrow, tbl[i].vop, tbl[i].a, tbl[i].b, ro, rr, rf, rc, lat);
      checks++;
      if ({ro, rr, rf, rc} !== {tbl[i].eo, tbl[i].er, tbl[i].ef, tbl[i].ec}) begin
        errors++;
        $display("FAIL directed[%0d]: out=%h rem=%h flags=%b cout=%b, required out=%h rem=%h flags=%b cout=%b",
                 i, ro, rr, rf, rc, tbl[i].eo, tbl[i].er, tbl[i].ef, tbl[i].ec);
      end
      checks++;
      if (lat !== tbl[i].elat) begin
        errors++;
        $display("FAIL directed_lat[%0d]: latency=%0d, required %0d", i, lat, tbl[i].elat);
      end
    end
  endtask

  task automatic test_random(input bit narrow, input int n);
    logic [63:0] a, b, ro, rr, eo, er;
    logic [3:0] rf, ef;
    logic rc;
    logic [4:0] rop;
    int lat, elat, w;
    w = narrow ? 8 : 36;
    for (int i = 0; i < n; i++) begin
      rop = ($urandom_range(0, 7) == 7) ? 5'($urandom_range(6, 31)) : 5'($urandom_range(0, 5));
      a = rand_opnd(w);
      b = rand_opnd(w);
      model(w, rop, a, b, eo, er, ef, elat);
      run_op(narrow, rop, a, b, ro, rr, rf, rc, lat);
      checks++;
      if ({ro, rr, rf, rc, lat} !== {eo, er, ef, ef[1], elat}) begin
        errors++;
        $display("FAIL random%0d[%0d] op=%0d a=%h b=%h: out=%h rem=%h flags=%b cout=%b lat=%0d, required %h %h %b %b %0d",
                 w, i, rop, a, b, ro, rr, rf, rc, lat, eo, er, ef, ef[1], elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; in1 = 36'd3; in2 = 36'd4;
    @(posedge clk); #1;
    op = OP_SUB; in1 = 36'd20; in2 = 36'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out, rem, flags} !== {1'b1, 1'b0, 36'd7, 36'd0, 4'b0000}) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b ready=%b out=%h rem=%h flags=%b, required 1 0 7 0 0000",
                 k, out_valid, in_ready, out, rem, flags);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL handshake_drop: valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out, flags} !== {1'b1, 36'd14, 4'b0000}) begin
      errors++;
      $display("FAIL second_op: valid=%b out=%h flags=%b, required 1 00000000e 0000", out_valid, out, flags);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    logic [63:0] ro, rr;
    logic [3:0] rf;
    logic rc;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = OP_DIVIDE; in1 = 36'h9_8765_4321; in2 = 36'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out, rem, flags, cout} !== {1'b0, 1'b1, 36'd0, 36'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b out=%h rem=%h flags=%b cout=%b, required 0 1 0 0 0 0",
               out_valid, in_ready, out, rem, flags, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL aborted_div_valid[%0d]: out_valid=%b, required 0", k, out_valid);
      end
    end
    run_op(1'b0, OP_AND, 64'hF0F, 64'h0FF, ro, rr, rf, rc, lat);
    checks++;
    if ({ro, rr, rf, lat} !== {64'h00F, 64'd0, 4'b0000, 1}) begin
      errors++;
      $display("FAIL post_reset_and: out=%h rem=%h flags=%b lat=%0d, required 00f 0 0000 1", ro, rr, rf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(1'b0, 60);
    test_random(1'b1, 40);
    test_back_to_back();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
